// File: rtl/mem_bridge_pkg.sv
// Shared definitions for cpu_mem_bridge: FSM state encoding, request side and
// kind tags, and the width of the SRAM latency counter.
// No ports; imported by the bridge.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // waiting for a CPU request
    ST_ACCESS = 2'd1,  // single SRAM enable cycle
    ST_WAIT   = 2'd2,  // counting down remaining read latency
    ST_RESP   = 2'd3   // response valid, waiting for CPU ack
  } state_e;

  typedef enum logic {
    KIND_READ  = 1'b0,
    KIND_WRITE = 1'b1
  } kind_e;

  // Which CPU channel owns the access in flight.
  localparam logic SIDE_INST = 1'b0;
  localparam logic SIDE_DATA = 1'b1;

  // Latency counter width; supports read latencies 1..15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/cpu_mem_bridge.sv
// Purpose : serialises the CPU fetch and data channels onto one single-port
//           synchronous SRAM with a fixed read latency.
// Latency : request handshake at edge E -> read response valid from edge E+LATENCY;
//           stores complete one cycle after the handshake with no response.
// Backpr. : one access at a time; request acks stay low while busy and a
//           response is held until the matching CPU ack.
// Ports   : clk/resetn; inst_req_* / Inst_Req_Ack fetch request; inst_rdata /
//           Inst_Valid / Inst_Ack fetch response; mem_req_* / Mem_Req_Ack data
//           request; read_data / Read_data_Valid / Read_data_Ack load response;
//           sram_* SRAM port.
module cpu_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                resetn,
  // fetch request / response
  input  logic [ADDR_W-1:0]   inst_req_addr,
  input  logic                Inst_Req_Valid,
  output logic                Inst_Req_Ack,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                Inst_Valid,
  input  logic                Inst_Ack,
  // data request / load response
  input  logic                mem_req_valid,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic [DATA_W/8-1:0] mem_req_wen,
  input  logic [DATA_W-1:0]   mem_req_wdata,
  output logic                Mem_Req_Ack,
  output logic [DATA_W-1:0]   read_data,
  output logic                Read_data_Valid,
  input  logic                Read_data_Ack,
  // SRAM port
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int STRB_W = DATA_W / 8;
  // ACCESS already covers the first latency cycle, so WAIT counts the rest.
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LATENCY - 1);

  state_e              state_q;
  logic [LAT_W-1:0]    cnt_q;
  logic                side_q;
  kind_e               kind_q;
  logic                sram_en_q;
  logic [STRB_W-1:0]   sram_wen_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [DATA_W-1:0]   sram_wdata_q;
  logic [DATA_W-1:0]   inst_rdata_q;
  logic [DATA_W-1:0]   read_data_q;
  logic                inst_vld_q;
  logic                rd_vld_q;

  logic                idle;
  logic                mem_ack;
  logic                inst_ack;
  logic                req_fire;
  logic                req_side_d;
  logic [ADDR_W-1:0]   req_addr_d;
  logic [STRB_W-1:0]   req_wen_d;
  logic [DATA_W-1:0]   req_wdata_d;
  logic                capture_d;
  logic                resp_ack;

  // Acks are combinational in IDLE; data wins a collision with a fetch.
  // Gated by resetn so every output reads 0 while reset is held.
  assign idle     = (state_q == ST_IDLE) && resetn;
  assign mem_ack  = idle && mem_req_valid;
  assign inst_ack = idle && Inst_Req_Valid && !mem_req_valid;
  assign req_fire = mem_ack || inst_ack;

  // Request mux: fetches never write.
  assign req_side_d  = mem_req_valid ? SIDE_DATA     : SIDE_INST;
  assign req_addr_d  = mem_req_valid ? mem_req_addr  : inst_req_addr;
  assign req_wen_d   = mem_req_valid ? mem_req_wen   : '0;
  assign req_wdata_d = mem_req_valid ? mem_req_wdata : '0;

  // sram_rdata is valid on the edge ending ACCESS when LATENCY is 1,
  // otherwise on the edge where the WAIT countdown reaches 1.
  assign capture_d = ((state_q == ST_ACCESS) && (kind_q == KIND_READ) && (LATENCY == 1))
                  || ((state_q == ST_WAIT) && (cnt_q == LAT_W'(1)));

  // Only the ack of the channel that owns the response retires it.
  assign resp_ack = (side_q == SIDE_INST) ? Inst_Ack : Read_data_Ack;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      side_q       <= SIDE_INST;
      kind_q       <= KIND_READ;
      sram_en_q    <= 1'b0;
      sram_wen_q   <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      inst_rdata_q <= '0;
      read_data_q  <= '0;
      inst_vld_q   <= 1'b0;
      rd_vld_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            state_q      <= ST_ACCESS;
            sram_en_q    <= 1'b1;
            sram_addr_q  <= req_addr_d;
            sram_wen_q   <= req_wen_d;
            sram_wdata_q <= req_wdata_d;
            side_q       <= req_side_d;
            kind_q       <= (req_wen_d == '0) ? KIND_READ : KIND_WRITE;
          end
        end
        ST_ACCESS: begin
          sram_en_q  <= 1'b0;
          sram_wen_q <= '0;
          if (kind_q == KIND_WRITE) begin
            state_q <= ST_IDLE;  // store retired at this edge, no response
          end else if (LATENCY == 1) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q   <= LAT_RELOAD;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ack) begin
            inst_vld_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Response registers are loaded only on the capture edge and then
      // held stable through RESP.
      if (capture_d) begin
        if (side_q == SIDE_INST) begin
          inst_rdata_q <= sram_rdata;
          inst_vld_q   <= 1'b1;
        end else begin
          read_data_q <= sram_rdata;
          rd_vld_q    <= 1'b1;
        end
      end
    end
  end

  assign Inst_Req_Ack    = inst_ack;
  assign Mem_Req_Ack     = mem_ack;
  assign inst_rdata      = inst_rdata_q;
  assign Inst_Valid      = inst_vld_q;
  assign read_data       = read_data_q;
  assign Read_data_Valid = rd_vld_q;
  assign sram_en         = sram_en_q;
  assign sram_wen        = sram_wen_q;
  assign sram_addr       = sram_addr_q;
  assign sram_wdata      = sram_wdata_q;

endmodule
